// File: rtl/hazard_tag_pkg.sv
// Shared widths, stage-entry encoding and helpers for hazard tag tracking.
// Used by both the tag pipeline and the stall generator.
package hazard_tag_pkg;

  localparam int WA_W   = 5;
  localparam int TNEW_W = 2;
  localparam int CNT_W  = 16;

  typedef struct packed {
    logic [WA_W-1:0]   wa;
    logic [TNEW_W-1:0] tnew;
  } tag_t;

  localparam tag_t BUBBLE = '{wa: '0, tnew: '0};

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Saturating decrement: a result that already exists stays at 0.
  function automatic logic [TNEW_W-1:0] satdec(
    input logic [TNEW_W-1:0] x
  );
    return (x == '0) ? '0 : x - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_tag_pipeline_stage.sv
// One hazard tag entry register with bubble and
// optional saturating decrement on load.
module hazard_tag_stage
  import hazard_tag_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic bubble,
  input  logic dec,
  input  tag_t d,
  output tag_t q
);

  tag_t nxt;

  always_comb begin
    nxt = d;
    if (dec) nxt.tnew = satdec(d.tnew);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= BUBBLE;
    end else if (bubble) begin
      q <= BUBBLE;
    end else if (load) begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/hazard_tag_pipeline.sv
// Tracks destination register and remaining latency of in-flight
// instructions in EX/MEM/WB for forwarding and stall decisions.
module hazard_tag_pipeline
  import hazard_tag_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WA_W-1:0]   WA_ID,
  input  logic [TNEW_W-1:0] Tnew_ID,
  input  logic              Stall,
  input  logic              Clear,
  output logic [WA_W-1:0]   WA_EX,
  output logic [WA_W-1:0]   WA_MEM,
  output logic [WA_W-1:0]   WA_WB,
  output logic [TNEW_W-1:0] Tnew_EX,
  output logic [TNEW_W-1:0] Tnew_MEM,
  output logic [TNEW_W-1:0] Tnew_WB,
  output logic              Ready_EX,
  output logic              Ready_MEM,
  output logic              Ready_WB,
  output logic [CNT_W-1:0]  Stall_Count
);

  tag_t id_d;
  tag_t ex_q;
  tag_t mem_q;
  tag_t wb_q;
  logic ex_bub;

  assign id_d   = '{wa: WA_ID, tnew: Tnew_ID};
  // r0 never creates a hazard, so it is tracked as a bubble.
  assign ex_bub = Clear | Stall | (WA_ID == '0);

  hazard_tag_stage u_ex (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (ex_bub),
    .dec    (1'b0),
    .d      (id_d),
    .q      (ex_q)
  );

  hazard_tag_stage u_mem (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (Clear),
    .dec    (1'b1),
    .d      (ex_q),
    .q      (mem_q)
  );

  hazard_tag_stage u_wb (
    .clk    (clk),
    .reset  (reset),
    .load   (1'b1),
    .bubble (Clear),
    .dec    (1'b1),
    .d      (mem_q),
    .q      (wb_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      Stall_Count <= '0;
    end else if (Stall && !Clear &&
                 (Stall_Count != CNT_MAX)) begin
      Stall_Count <= Stall_Count + 1'b1;
    end
  end

  assign WA_EX    = ex_q.wa;
  assign WA_MEM   = mem_q.wa;
  assign WA_WB    = wb_q.wa;
  assign Tnew_EX  = ex_q.tnew;
  assign Tnew_MEM = mem_q.tnew;
  assign Tnew_WB  = wb_q.tnew;

  assign Ready_EX  = reset && (ex_q.wa != '0) &&
                     (ex_q.tnew == '0);
  assign Ready_MEM = reset && (mem_q.wa != '0) &&
                     (mem_q.tnew == '0);
  assign Ready_WB  = reset && (wb_q.wa != '0) &&
                     (wb_q.tnew == '0);

endmodule
